// File: rtl/game_pkg.sv
// Shared game constants and the collision-scan FSM state type.
package game_pkg;

  localparam int unsigned BULLET_COUNT = 8;
  localparam int unsigned ENEMY_COUNT  = 4;

  localparam int unsigned BULLET_W = 2;
  localparam int unsigned BULLET_H = 4;
  localparam int unsigned ENEMY_W  = 16;
  localparam int unsigned ENEMY_H  = 16;

  localparam int unsigned SCREEN_W = 640;
  localparam int unsigned SCREEN_H = 480;

  // Every sprite coordinate on the bus is this wide.
  localparam int unsigned COORD_W = 10;

  typedef enum logic [1:0] {
    StIdle,
    StScan,
    StReport
  } scan_state_e;

endpackage

// File: rtl/rect_overlap.sv
// Combinational axis-aligned box overlap test between box A and box B.
// Edges that merely touch do not count as overlapping.
module rect_overlap #(
  parameter int unsigned AWidth  = 2,
  parameter int unsigned AHeight = 4,
  parameter int unsigned BWidth  = 16,
  parameter int unsigned BHeight = 16,
  parameter int unsigned CoordW  = 10
) (
  input  logic [CoordW-1:0] a_x_i,
  input  logic [CoordW-1:0] a_y_i,
  input  logic [CoordW-1:0] b_x_i,
  input  logic [CoordW-1:0] b_y_i,
  output logic              hit
);

  // One spare bit so that coordinate + size never wraps near the screen edge.
  localparam int unsigned ExtW = CoordW + 1;

  logic [ExtW-1:0] ax, ay, bx, by;

  assign ax = {1'b0, a_x_i};
  assign ay = {1'b0, a_y_i};
  assign bx = {1'b0, b_x_i};
  assign by = {1'b0, b_y_i};

  assign hit = (ax < bx + ExtW'(BWidth))  &&
               (ax + ExtW'(AWidth) > bx)  &&
               (ay < by + ExtW'(BHeight)) &&
               (ay + ExtW'(AHeight) > by);

endmodule

// File: rtl/bullet_hit_detector.sv
// Per-frame bullet/enemy collision resolver. Snapshots all boxes on frame_tick,
// walks every bullet x enemy pair through one shared comparator (enemy index
// innermost), then emits a single-cycle hit/kill/score pulse.
module bullet_hit_detector #(
  parameter int unsigned BULLET_COUNT = game_pkg::BULLET_COUNT,
  parameter int unsigned ENEMY_COUNT  = game_pkg::ENEMY_COUNT,
  parameter int unsigned BULLET_W     = game_pkg::BULLET_W,
  parameter int unsigned BULLET_H     = game_pkg::BULLET_H,
  parameter int unsigned ENEMY_W      = game_pkg::ENEMY_W,
  parameter int unsigned ENEMY_H      = game_pkg::ENEMY_H,
  parameter int unsigned CNT_W        = $clog2(BULLET_COUNT + 1)
) (
  input  logic                                    clk25,
  input  logic                                    rst_n,
  input  logic                                    frame_tick,
  input  logic [game_pkg::COORD_W*BULLET_COUNT-1:0] bullet_x_flat,
  input  logic [game_pkg::COORD_W*BULLET_COUNT-1:0] bullet_y_flat,
  input  logic [BULLET_COUNT-1:0]                 bullet_active,
  input  logic [game_pkg::COORD_W*ENEMY_COUNT-1:0]  enemy_x_flat,
  input  logic [game_pkg::COORD_W*ENEMY_COUNT-1:0]  enemy_y_flat,
  input  logic [ENEMY_COUNT-1:0]                  enemy_alive,
  output logic [BULLET_COUNT-1:0]                 bullet_hit,
  output logic [ENEMY_COUNT-1:0]                  enemy_kill,
  output logic [CNT_W-1:0]                        score_inc,
  output logic                                    busy
);

  import game_pkg::*;

  localparam int unsigned BIdxW = (BULLET_COUNT > 1) ? $clog2(BULLET_COUNT) : 1;
  localparam int unsigned EIdxW = (ENEMY_COUNT > 1) ? $clog2(ENEMY_COUNT) : 1;
  localparam int unsigned BXW   = COORD_W * BULLET_COUNT;
  localparam int unsigned EXW   = COORD_W * ENEMY_COUNT;

  scan_state_e state_q, state_d;

  // Frame snapshot; the scan only ever looks at these.
  logic [BXW-1:0]          snap_bx_q, snap_by_q;
  logic [BULLET_COUNT-1:0] snap_act_q;
  logic [EXW-1:0]          snap_ex_q, snap_ey_q;
  logic [ENEMY_COUNT-1:0]  snap_alive_q;
  logic                    snap_load;

  logic [BIdxW-1:0]        b_q, b_d;
  logic [EIdxW-1:0]        e_q, e_d;
  logic [BULLET_COUNT-1:0] pend_b_q, pend_b_d;
  logic [ENEMY_COUNT-1:0]  pend_e_q, pend_e_d;
  logic [CNT_W-1:0]        hit_cnt_q, hit_cnt_d;

  logic [BULLET_COUNT-1:0] bullet_hit_q, bullet_hit_d;
  logic [ENEMY_COUNT-1:0]  enemy_kill_q, enemy_kill_d;
  logic [CNT_W-1:0]        score_inc_q, score_inc_d;
  logic                    busy_q, busy_d;

  logic [COORD_W-1:0]      cur_bx, cur_by, cur_ex, cur_ey;
  logic                    geom_hit;
  logic                    pair_hit;
  logic                    last_e;
  logic                    last_pair;

  // Select the current pair's boxes out of the snapshot.
  always_comb begin
    cur_bx = snap_bx_q[COORD_W*int'(b_q) +: COORD_W];
    cur_by = snap_by_q[COORD_W*int'(b_q) +: COORD_W];
    cur_ex = snap_ex_q[COORD_W*int'(e_q) +: COORD_W];
    cur_ey = snap_ey_q[COORD_W*int'(e_q) +: COORD_W];
  end

  rect_overlap #(
    .AWidth  (BULLET_W),
    .AHeight (BULLET_H),
    .BWidth  (ENEMY_W),
    .BHeight (ENEMY_H),
    .CoordW  (COORD_W)
  ) u_overlap (
    .a_x_i (cur_bx),
    .a_y_i (cur_by),
    .b_x_i (cur_ex),
    .b_y_i (cur_ey),
    .hit   (geom_hit)
  );

  // Already-claimed bullets and enemies are skipped, which gives lowest-b,
  // then lowest-e priority for free from the scan order.
  always_comb begin
    pair_hit  = geom_hit && snap_act_q[b_q] && snap_alive_q[e_q] &&
                !pend_b_q[b_q] && !pend_e_q[e_q];
    last_e    = (e_q == EIdxW'(ENEMY_COUNT - 1));
    last_pair = last_e && (b_q == BIdxW'(BULLET_COUNT - 1));
  end

  // Next-state logic: FSM, pair walk, pending masks and output pulse.
  always_comb begin
    state_d      = state_q;
    snap_load    = 1'b0;
    b_d          = b_q;
    e_d          = e_q;
    pend_b_d     = pend_b_q;
    pend_e_d     = pend_e_q;
    hit_cnt_d    = hit_cnt_q;
    bullet_hit_d = bullet_hit_q;
    enemy_kill_d = enemy_kill_q;
    score_inc_d  = score_inc_q;

    unique case (state_q)
      StIdle: begin
        if (frame_tick) begin
          state_d   = StScan;
          snap_load = 1'b1;
          b_d       = '0;
          e_d       = '0;
          pend_b_d  = '0;
          pend_e_d  = '0;
          hit_cnt_d = '0;
        end
      end
      StScan: begin
        if (pair_hit) begin
          pend_b_d[b_q] = 1'b1;
          pend_e_d[e_q] = 1'b1;
          hit_cnt_d     = hit_cnt_q + CNT_W'(1);
        end
        if (last_pair) begin
          // Use the _d values so the final pair's result is included.
          state_d      = StReport;
          bullet_hit_d = pend_b_d;
          enemy_kill_d = pend_e_d;
          score_inc_d  = hit_cnt_d;
        end else if (last_e) begin
          e_d = '0;
          b_d = b_q + BIdxW'(1);
        end else begin
          e_d = e_q + EIdxW'(1);
        end
      end
      StReport: begin
        state_d      = StIdle;
        bullet_hit_d = '0;
        enemy_kill_d = '0;
        score_inc_d  = '0;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    busy_d = (state_d != StIdle);
  end

  // FSM, scan indices, pending state and registered outputs.
  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      b_q          <= '0;
      e_q          <= '0;
      pend_b_q     <= '0;
      pend_e_q     <= '0;
      hit_cnt_q    <= '0;
      bullet_hit_q <= '0;
      enemy_kill_q <= '0;
      score_inc_q  <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      b_q          <= b_d;
      e_q          <= e_d;
      pend_b_q     <= pend_b_d;
      pend_e_q     <= pend_e_d;
      hit_cnt_q    <= hit_cnt_d;
      bullet_hit_q <= bullet_hit_d;
      enemy_kill_q <= enemy_kill_d;
      score_inc_q  <= score_inc_d;
      busy_q       <= busy_d;
    end
  end

  // Capture every box and live flag at scan start.
  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      snap_bx_q    <= '0;
      snap_by_q    <= '0;
      snap_act_q   <= '0;
      snap_ex_q    <= '0;
      snap_ey_q    <= '0;
      snap_alive_q <= '0;
    end else if (snap_load) begin
      snap_bx_q    <= bullet_x_flat;
      snap_by_q    <= bullet_y_flat;
      snap_act_q   <= bullet_active;
      snap_ex_q    <= enemy_x_flat;
      snap_ey_q    <= enemy_y_flat;
      snap_alive_q <= enemy_alive;
    end
  end

  assign bullet_hit = bullet_hit_q;
  assign enemy_kill = enemy_kill_q;
  assign score_inc  = score_inc_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_bullet_hit_detector.sv
// Self-checking bench for bullet_hit_detector: directed scenes plus random
// scenes, each checked against a frame-level collision model.
module tb_bullet_hit_detector;

  localparam int NB = 8;
  localparam int NE = 4;

  logic          clk25 = 1'b0;
  logic          rst_n;
  logic          frame_tick;
  logic [10*NB-1:0] bullet_x_flat, bullet_y_flat;
  logic [NB-1:0] bullet_active;
  logic [10*NE-1:0] enemy_x_flat, enemy_y_flat;
  logic [NE-1:0] enemy_alive;
  logic [NB-1:0] bullet_hit;
  logic [NE-1:0] enemy_kill;
  logic [3:0]    score_inc;
  logic          busy;

  int unsigned bx[NB], by[NB], ex[NE], ey[NE];
  bit          act[NB], alive[NE];

  int total = 0;
  int bad   = 0;

  always #5 clk25 = ~clk25;

  bullet_hit_detector dut (
    .clk25         (clk25),
    .rst_n         (rst_n),
    .frame_tick    (frame_tick),
    .bullet_x_flat (bullet_x_flat),
    .bullet_y_flat (bullet_y_flat),
    .bullet_active (bullet_active),
    .enemy_x_flat  (enemy_x_flat),
    .enemy_y_flat  (enemy_y_flat),
    .enemy_alive   (enemy_alive),
    .bullet_hit    (bullet_hit),
    .enemy_kill    (enemy_kill),
    .score_inc     (score_inc),
    .busy          (busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NB; i++) begin
      bullet_x_flat[10*i +: 10] = bx[i][9:0];
      bullet_y_flat[10*i +: 10] = by[i][9:0];
      bullet_active[i]          = act[i];
    end
    for (int j = 0; j < NE; j++) begin
      enemy_x_flat[10*j +: 10] = ex[j][9:0];
      enemy_y_flat[10*j +: 10] = ey[j][9:0];
      enemy_alive[j]           = alive[j];
    end
  endtask

  task automatic clear_scene();
    for (int i = 0; i < NB; i++) begin bx[i] = 0; by[i] = 0; act[i] = 0; end
    for (int j = 0; j < NE; j++) begin ex[j] = 500; ey[j] = 400; alive[j] = 0; end
  endtask

  task automatic rand_scene();
    for (int j = 0; j < NE; j++) begin
      ex[j]    = $urandom_range(80, 200);
      ey[j]    = $urandom_range(80, 200);
      alive[j] = ($urandom_range(0, 3) != 0);
    end
    for (int i = 0; i < NB; i++) begin
      bx[i]  = $urandom_range(70, 230);
      by[i]  = $urandom_range(70, 230);
      act[i] = ($urandom_range(0, 3) != 0);
    end
  endtask

  // Frame result: bullets in order each take the first still-free live
  // enemy whose box strictly overlaps theirs.
  function automatic void model(output logic [7:0] hb, output logic [3:0] ke,
                                output int sc);
    hb = '0; ke = '0; sc = 0;
    for (int b = 0; b < NB; b++) begin
      if (!act[b]) continue;
      for (int e = 0; e < NE; e++) begin
        if (alive[e] && !ke[e] &&
            bx[b] < ex[e] + 16 && bx[b] + 2 > ex[e] &&
            by[b] < ey[e] + 16 && by[b] + 4 > ey[e]) begin
          hb[b] = 1'b1;
          ke[e] = 1'b1;
          sc++;
          break;
        end
      end
    end
  endfunction

  task automatic pulse_tick();
    @(negedge clk25); frame_tick = 1'b1;
    @(negedge clk25); frame_tick = 1'b0;
  endtask

  // Runs one frame. Optionally rewrites inputs at T+5 and re-ticks at T+10.
  task automatic run_frame(input string name, input bit perturb);
    logic [7:0] eb;
    logic [3:0] ek;
    int         es;
    int         quiet;
    drive();
    model(eb, ek, es);
    pulse_tick();
    quiet = 0;
    for (int k = 1; k <= 32; k++) begin
      if (busy === 1'b1 && bullet_hit === '0 && enemy_kill === '0 && score_inc === '0)
        quiet++;
      if (perturb && k == 5) begin rand_scene(); drive(); end
      if (perturb && k == 10) frame_tick = 1'b1;
      if (perturb && k == 11) frame_tick = 1'b0;
      @(negedge clk25);
    end
    chk({name, "_scan"}, quiet, 32);
    chk({name, "_hit"}, bullet_hit, eb);
    chk({name, "_kill"}, enemy_kill, ek);
    chk({name, "_score"}, score_inc, es);
    chk({name, "_busy33"}, busy, 1);
    @(negedge clk25);
    chk({name, "_clr"}, {bullet_hit, enemy_kill, score_inc}, 0);
    chk({name, "_idle"}, busy, 0);
    if (perturb) begin
      quiet = 0;
      for (int k = 0; k < 40; k++) begin
        if (busy === 1'b0 && bullet_hit === '0 && score_inc === '0) quiet++;
        @(negedge clk25);
      end
      chk({name, "_noretick"}, quiet, 40);
    end
  endtask

  initial begin
    int quiet;
    rst_n = 1'b0;
    frame_tick = 1'b0;
    clear_scene();
    drive();
    repeat (3) @(negedge clk25);
    chk("rst_hit", bullet_hit, 0);
    chk("rst_kill", enemy_kill, 0);
    chk("rst_score", score_inc, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    @(negedge clk25);

    // Basic single hit.
    clear_scene();
    bx[0] = 100; by[0] = 100; act[0] = 1;
    ex[0] = 96;  ey[0] = 92;  alive[0] = 1;
    run_frame("basic", 0);

    // Touching edges do not overlap; one pixel in does.
    bx[0] = 112; run_frame("edge_x_touch", 0);
    bx[0] = 111; run_frame("edge_x_in", 0);
    bx[0] = 100; by[0] = 108; run_frame("edge_y_touch", 0);
    by[0] = 88;  run_frame("edge_y_top", 0);
    by[0] = 89;  run_frame("edge_y_in", 0);

    // Two bullets on one enemy: only the lower index wins.
    clear_scene();
    bx[2] = 300; by[2] = 200; act[2] = 1;
    bx[5] = 305; by[5] = 205; act[5] = 1;
    ex[3] = 298; ey[3] = 198; alive[3] = 1;
    run_frame("tie", 0);

    // Nothing live on one side.
    for (int i = 0; i < NB; i++) act[i] = 0;
    run_frame("no_bullets", 0);
    for (int i = 0; i < NB; i++) begin bx[i] = 300; by[i] = 200; act[i] = 1; end
    alive[3] = 0;
    run_frame("no_enemies", 0);

    // Boxes at the far screen edge must not wrap.
    clear_scene();
    ex[1] = 1020; ey[1] = 1000; alive[1] = 1;
    bx[6] = 1022; by[6] = 1010; act[6] = 1;
    run_frame("far_edge", 0);

    // Mid-scan input change and ignored second tick.
    rand_scene();
    bx[0] = ex[0] + 3; by[0] = ey[0] + 3; act[0] = 1; alive[0] = 1;
    run_frame("snapshot", 1);

    // Reset mid-scan aborts with no pulse.
    drive();
    pulse_tick();
    repeat (19) @(negedge clk25);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_out", {bullet_hit, enemy_kill, score_inc}, 0);
    repeat (2) @(negedge clk25);
    rst_n = 1'b1;
    quiet = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk25);
      if (busy === 1'b0 && bullet_hit === '0 && enemy_kill === '0 && score_inc === '0)
        quiet++;
    end
    chk("abort_quiet", quiet, 20);
    run_frame("after_abort", 0);

    // Random scenes.
    for (int n = 0; n < 20; n++) begin
      rand_scene();
      run_frame($sformatf("rand%0d", n), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time bound so the bench cannot hang.
  initial begin
    #500000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "time limit");
  end

endmodule
